// File: rtl/pipe_hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package pipe_hilo_pkg;

  localparam int XLEN       = 32;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_FIXUP
  } state_e;

  // Two's-complement negate when neg is set; used for abs() and sign fixup.
  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/pipe_div_iter.sv
// Unsigned restoring divider core: one quotient bit per cycle, MSB first.
module pipe_div_iter
  import pipe_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_last,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fit;

  // Partial remainder shifted left by one with the next dividend bit; subtract
  // the divisor and keep the difference only when it does not borrow.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_fit   = ~w_diff[WIDTH];

  assign o_last = r_active && (r_cnt == CNT_W'(DIV_CYCLES - 1));
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

  // NOTE: the datapath registers are plain flops, not a memory array, so they
  // are all cleared by reset and a divide aborted by reset leaves no residue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
    end else if (i_flush) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      // NOTE: non-blocking assignments here, so every register in this block
      // samples pre-edge values regardless of statement order.
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= i_dividend;
      r_div    <= i_divisor;
    end else if (r_active) begin
      r_rem <= w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_fit};
      r_cnt <= r_cnt + 1'b1;
      if (o_last) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_hilo_unit.sv
// MIPS-style HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO, 34-cycle DIV/DIVU.
module pipe_hilo_unit
  import pipe_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              w_op;

  logic             w_accept;
  logic             w_is_div;
  logic             w_is_signed_div;
  logic             w_load;
  logic             w_write_div;
  logic             w_write_now;
  logic             w_last;

  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;

  logic [WIDTH-1:0] w_dividend;
  logic [WIDTH-1:0] w_divisor;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_b_zero;
  logic [WIDTH-1:0] r_raw_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  assign w_op            = op_e'(Op);
  assign w_accept        = Start && !Flush && (r_state == ST_IDLE);
  assign w_is_div        = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_is_signed_div = (w_op == OP_DIV);
  assign w_write_now     = w_accept && ((w_op == OP_MULT) || (w_op == OP_MULTU) ||
                                        (w_op == OP_MTHI) || (w_op == OP_MTLO));

  // The low 2*WIDTH bits of a product are the same for signed and unsigned
  // operands once each operand is extended the right way.
  assign w_a_ext = (w_op == OP_MULT) ? {{WIDTH{SrcA[WIDTH-1]}}, SrcA} : {{WIDTH{1'b0}}, SrcA};
  assign w_b_ext = (w_op == OP_MULT) ? {{WIDTH{SrcB[WIDTH-1]}}, SrcB} : {{WIDTH{1'b0}}, SrcB};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_dividend = cond_neg(w_is_signed_div && SrcA[WIDTH-1], SrcA);
  assign w_divisor  = cond_neg(w_is_signed_div && SrcB[WIDTH-1], SrcB);

  pipe_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_flush   (Flush),
    .i_dividend(w_dividend),
    .i_divisor (w_divisor),
    .o_last    (w_last),
    .o_quo     (w_quo),
    .o_rem     (w_rem)
  );

  assign w_quo_fix = cond_neg(r_neg_q, w_quo);
  assign w_rem_fix = cond_neg(r_neg_r, w_rem);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_write_div = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_div) begin
          w_state_nxt = ST_DIV;
          w_load      = 1'b1;
        end
      end
      ST_DIV: begin
        if (Flush) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        w_state_nxt = ST_IDLE;
        w_write_div = !Flush;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sign and zero-divisor context is captured with the operands, since SrcA
  // and SrcB are free to change while the divide runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_raw_a  <= '0;
    end else if (w_load) begin
      r_neg_q  <= w_is_signed_div && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
      r_neg_r  <= w_is_signed_div && SrcA[WIDTH-1];
      r_b_zero <= (SrcB == '0);
      r_raw_a  <= SrcA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_write_now || w_write_div;
      if (w_accept) begin
        case (w_op)
          OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod;
          OP_MTHI:           r_hi <= SrcA;
          OP_MTLO:           r_lo <= SrcA;
          default: ;
        endcase
      end else if (w_write_div) begin
        r_hi <= r_b_zero ? r_raw_a : w_rem_fix;
        r_lo <= r_b_zero ? '1      : w_quo_fix;
      end
    end
  end

  assign Busy = (r_state != ST_IDLE);
  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

endmodule

// File: tb/tb_pipe_hilo_unit.sv
// Self-checking bench for pipe_hilo_unit: vector table plus scoreboard queue.
module tb_pipe_hilo_unit;
  import pipe_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  pipe_hilo_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .Op   (Op),
    .SrcA (SrcA),
    .SrcB (SrcB),
    .Flush(Flush),
    .Busy (Busy),
    .Done (Done),
    .Hi   (Hi),
    .Lo   (Lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Start is driven at a falling edge and sampled at the next rising edge (E0).
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic with_flush, input logic release_reset);
    @(negedge clk);
    if (release_reset) reset = 1'b1;
    Start = 1'b1;
    Op    = op;
    SrcA  = a;
    SrcB  = b;
    Flush = with_flush;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Flush = 1'b0;
  endtask

  // Observes 40 cycles after E0; falling edge n is the cycle following edge E(n-1).
  task automatic watch(input int exp_lat, input int exp_busy, input logic [31:0] hold_hi,
                       input logic [31:0] hold_lo, input int inject_at, input int flush_at,
                       input string name);
    int          busy_cnt  = 0;
    int          done_cnt  = 0;
    int          first_done = -1;
    logic [63:0] exp;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (first_done < 0) first_done = n;
        if (sb_q.size() == 0) begin
          check({name, " unexpected done"}, 64'(n), 64'(0));
        end else begin
          exp = sb_q.pop_front();
          check({name, " hi"}, {32'd0, Hi}, {32'd0, exp[63:32]});
          check({name, " lo"}, {32'd0, Lo}, {32'd0, exp[31:0]});
        end
      end
      if (n == inject_at) begin
        Start = 1'b1;
        Op    = OP_DIV;
        SrcA  = 32'd9;
        SrcB  = 32'd3;
      end else if (n == inject_at + 1) begin
        Start = 1'b0;
      end
      if (n == flush_at) Flush = 1'b1;
      else if (n == flush_at + 1) Flush = 1'b0;
    end
    check({name, " done count"}, 64'(done_cnt), (exp_lat > 0) ? 64'd1 : 64'd0);
    check({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
    if (exp_lat > 0) begin
      check({name, " done latency"}, 64'(first_done), 64'(exp_lat));
    end else begin
      check({name, " hi held"}, {32'd0, Hi}, {32'd0, hold_hi});
      check({name, " lo held"}, {32'd0, Lo}, {32'd0, hold_lo});
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.lat > 0) sb_q.push_back({v.hi, v.lo});
    drive_start(v.op, v.a, v.b, 1'b0, 1'b0);
    watch(v.lat, (v.lat == 34) ? 33 : 0, v.hi, v.lo, 0, 0, v.name);
  endtask

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  32'hFFFFFFFE, 32'h00000001, "multu max"};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000001, 1,  32'hFFFFFFFF, 32'hFFFFFFFF, "mult -1x1"};
    vecs[2]  = '{OP_MULT,  32'h00000003, 32'hFFFFFFFB, 1,  32'hFFFFFFFF, 32'hFFFFFFF1, "mult 3x-5"};
    vecs[3]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 1,  32'h3FFFFFFF, 32'h00000001, "mult maxpos"};
    vecs[4]  = '{OP_MULTU, 32'h80000000, 32'h00000002, 1,  32'h00000001, 32'h00000000, "multu carry"};
    vecs[5]  = '{OP_MTHI,  32'h12345678, 32'h0,        1,  32'h12345678, 32'h00000000, "mthi"};
    vecs[6]  = '{OP_MTLO,  32'hDEADBEEF, 32'h0,        1,  32'h12345678, 32'hDEADBEEF, "mtlo"};
    vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
    vecs[8]  = '{OP_DIVU,  32'd100,      32'h0,        34, 32'd100,      32'hFFFFFFFF, "divu 100/0"};
    vecs[9]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, "div min/-1"};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'd7,        34, 32'd3,        32'h24924924, "divu max/7"};
    vecs[11] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 34, 32'd1,        32'hFFFFFFFD, "div 7/-2"};
    vecs[12] = '{OP_DIV,   32'hFFFFFF9C, 32'h0,        34, 32'hFFFFFF9C, 32'hFFFFFFFF, "div -100/0"};
    vecs[13] = '{OP_DIV,   32'd20,       32'd5,        34, 32'd0,        32'd4,        "div 20/5"};
    vecs[14] = '{3'b110,   32'hCAFEF00D, 32'd1,        0,  32'd0,        32'd4,        "op 110 no-op"};

    reset = 1'b0;
    Start = 1'b0;
    Op    = 3'b000;
    SrcA  = '0;
    SrcB  = '0;
    Flush = 1'b0;
    #1;
    check("reset hi", {32'd0, Hi}, 64'd0);
    check("reset lo", {32'd0, Lo}, 64'd0);
    check("reset busy", {63'd0, Busy}, 64'd0);
    check("reset done", {63'd0, Done}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // A second divide Start while busy must be dropped.
    run_vec('{OP_MTHI, 32'h12345678, 32'h0, 1, 32'h12345678, 32'd4, "mthi before div"});
    sb_q.push_back({32'd0, 32'd10});
    drive_start(OP_DIV, 32'd50, 32'd5, 1'b0, 1'b0);
    watch(34, 33, 32'd0, 32'd10, 5, 0, "start while busy");

    // Flush mid-divide and during the fixup cycle: no write, no Done.
    drive_start(OP_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
    watch(0, 10, 32'd0, 32'd10, 0, 10, "flush cycle 10");
    drive_start(OP_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
    watch(0, 33, 32'd0, 32'd10, 0, 33, "flush in fixup");

    // Flush in idle cancels a same-cycle Start.
    drive_start(OP_MULT, 32'd5, 32'd5, 1'b1, 1'b0);
    watch(0, 0, 32'd0, 32'd10, 0, 0, "flush cancels start");

    // Reset in the middle of a divide clears state without a clock edge.
    run_vec('{OP_MTHI, 32'hAAAA5555, 32'h0, 1, 32'hAAAA5555, 32'd10, "mthi before reset"});
    drive_start(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    for (int n = 1; n <= 20; n++) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset hi", {32'd0, Hi}, 64'd0);
    check("midreset lo", {32'd0, Lo}, 64'd0);
    check("midreset busy", {63'd0, Busy}, 64'd0);
    check("midreset done", {63'd0, Done}, 64'd0);
    repeat (3) @(negedge clk);
    sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFF});
    drive_start(OP_MULT, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
    watch(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, "mult after reset");

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
